// File: rtl/iso14443a_reader_tx.sv
// ISO14443-A reader transmitter: byte handshake in, Modified Miller pause gating out.
// One holding register feeds one shift register; all state advances on the carrier negedge.
module iso14443a_reader_tx #(
    parameter int PAUSE_LEN = 32,
    parameter int BIT_LEN   = 128
) (
    input  logic       osc_clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic [2:0] tx_nbits,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       mod_pause,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [6:0] PH_LAST = 7'(BIT_LEN - 1);
    localparam logic [6:0] X_START = 7'd64;
    localparam logic [6:0] Z_END   = 7'(PAUSE_LEN);
    localparam logic [6:0] X_END   = 7'(64 + PAUSE_LEN);

    typedef enum logic [2:0] {S_IDLE, S_SOC, S_DATA, S_PAR, S_EOC0, S_EOC1} state_t;
    typedef enum logic [1:0] {SYM_NONE, SYM_X, SYM_Y, SYM_Z} sym_t;

    state_t     state_q;
    logic [6:0] ph_q;
    logic [7:0] hold_data_q;
    logic [2:0] hold_nbits_q;
    logic       hold_last_q;
    logic       hold_full_q;
    logic [7:0] sh_q;
    logic [2:0] nbits_q;
    logic       last_q;
    logic       par_q;
    logic [2:0] cnt_q;
    logic       prev_q;
    logic       urun_q;
    logic       mod_pause_q;
    logic       done_q;
    logic       underrun_q;

    logic [2:0] last_idx;
    logic       period_end;
    logic       last_bit;
    logic       cur_bit;
    sym_t       sym;
    logic       pause_d;
    logic       byte_end;
    logic       load;

    always_comb begin
        last_idx   = (nbits_q == 3'd0) ? 3'd7 : nbits_q - 3'd1;
        period_end = (ph_q == PH_LAST);
        last_bit   = (cnt_q == last_idx);
        cur_bit    = (state_q == S_PAR) ? par_q : sh_q[0];
        sym        = SYM_NONE;
        case (state_q)
            S_SOC:          sym = SYM_Z;
            S_DATA, S_PAR:  sym = cur_bit ? SYM_X : (prev_q ? SYM_Y : SYM_Z);
            S_EOC0:         sym = prev_q ? SYM_Y : SYM_Z;
            S_EOC1:         sym = SYM_Y;
            default:        sym = SYM_NONE;
        endcase
        pause_d  = ((sym == SYM_Z) && (ph_q < Z_END)) ||
                   ((sym == SYM_X) && (ph_q >= X_START) && (ph_q < X_END));
        byte_end = period_end &&
                   ((state_q == S_PAR) ||
                    ((state_q == S_DATA) && last_bit && (nbits_q != 3'd0)));
        // First byte moves in at SOC ph=0; later bytes at the byte boundary.
        load     = ((state_q == S_SOC) && (ph_q == 7'd0)) ||
                   (byte_end && !last_q && hold_full_q);
    end

    always_ff @(negedge osc_clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ph_q         <= 7'd0;
            hold_data_q  <= 8'd0;
            hold_nbits_q <= 3'd0;
            hold_last_q  <= 1'b0;
            hold_full_q  <= 1'b0;
            sh_q         <= 8'd0;
            nbits_q      <= 3'd0;
            last_q       <= 1'b0;
            par_q        <= 1'b0;
            cnt_q        <= 3'd0;
            prev_q       <= 1'b0;
            urun_q       <= 1'b0;
            mod_pause_q  <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            mod_pause_q <= pause_d;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            if (state_q != S_IDLE)
                ph_q <= ph_q + 7'd1;

            case (state_q)
                S_IDLE: if (hold_full_q) begin
                    state_q <= S_SOC;
                    ph_q    <= 7'd0;
                    prev_q  <= 1'b0;
                    urun_q  <= 1'b0;
                end
                S_SOC: if (period_end) state_q <= S_DATA;
                S_DATA: if (period_end) begin
                    prev_q <= sh_q[0];
                    if (!last_bit) begin
                        sh_q  <= {1'b0, sh_q[7:1]};
                        cnt_q <= cnt_q + 3'd1;
                    end else if (nbits_q == 3'd0) begin
                        state_q <= S_PAR;
                    end
                end
                S_PAR: if (period_end) prev_q <= par_q;
                S_EOC0: if (period_end) state_q <= S_EOC1;
                S_EOC1: if (period_end) begin
                    state_q    <= S_IDLE;
                    done_q     <= ~urun_q;
                    underrun_q <= urun_q;
                end
                default: state_q <= S_IDLE;
            endcase

            if (byte_end) begin
                if (last_q) begin
                    state_q <= S_EOC0;
                end else if (hold_full_q) begin
                    state_q <= S_DATA;
                end else begin
                    state_q <= S_EOC0;
                    urun_q  <= 1'b1;
                end
            end

            if (load) begin
                sh_q        <= hold_data_q;
                nbits_q     <= hold_nbits_q;
                last_q      <= hold_last_q;
                par_q       <= ~^hold_data_q;
                cnt_q       <= 3'd0;
                hold_full_q <= 1'b0;
            end else if (tx_valid && !hold_full_q) begin
                hold_data_q  <= tx_data;
                hold_nbits_q <= tx_nbits;
                hold_last_q  <= tx_last;
                hold_full_q  <= 1'b1;
            end
        end
    end

    assign tx_ready  = ~hold_full_q;
    assign busy      = (state_q != S_IDLE);
    assign mod_pause = mod_pause_q;
    assign done      = done_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_iso14443a_reader_tx.sv
// Bench for iso14443a_reader_tx: two instances (PAUSE_LEN 32 and 8) share stimulus and are
// compared cycle by cycle against a symbol-level Modified Miller model of each frame.
module tb_iso14443a_reader_tx;

    localparam int SZ = 0;
    localparam int SX = 1;
    localparam int SY = 2;

    logic       osc_clk;
    logic       rst;
    logic [7:0] tx_data;
    logic [2:0] tx_nbits;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready,  mod_pause,  busy,  done,  underrun;
    logic       tx_ready8, mod_pause8, busy8, done8, underrun8;

    iso14443a_reader_tx #(.PAUSE_LEN(32), .BIT_LEN(128)) u_dut (
        .osc_clk(osc_clk), .rst(rst), .tx_data(tx_data), .tx_nbits(tx_nbits),
        .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mod_pause(mod_pause), .busy(busy), .done(done), .underrun(underrun)
    );

    iso14443a_reader_tx #(.PAUSE_LEN(8), .BIT_LEN(128)) u_dut8 (
        .osc_clk(osc_clk), .rst(rst), .tx_data(tx_data), .tx_nbits(tx_nbits),
        .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready8),
        .mod_pause(mod_pause8), .busy(busy8), .done(done8), .underrun(underrun8)
    );

    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    int         syms[$];
    int         load_c[4];
    int         hs_c[4];
    logic [7:0] fr_data[4];
    logic [2:0] fr_nb[4];
    logic       fr_last[4];
    int         fr_n;
    int         hi32, hi8;

    function automatic bit exp_pause(input int pl, input int k);
        int p, ph;
        if (k < 0) return 1'b0;
        p  = k / 128;
        ph = k % 128;
        if (p >= syms.size()) return 1'b0;
        case (syms[p])
            SZ:      return ph < pl;
            SX:      return (ph >= 64) && (ph < 64 + pl);
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_byte(input int j, input logic [7:0] d, input logic [2:0] nb, input logic l);
        fr_data[j] = d;
        fr_nb[j]   = nb;
        fr_last[j] = l;
    endtask

    // Runs one frame held in fr_*; optionally hands off the next frame's first byte on the done cycle.
    task automatic run_frame(input string name, input bit pre_offered, input bit chain,
                             input logic [7:0] nd, input logic [2:0] nnb, input logic nl);
        int   s_start[4];
        int   nbt, prev, b, n_cyc, idx, off_at;
        int   m32, m8, mc, f32, f8, fc;
        bit   offering, urun, e_ready, e_busy, e_done, e_urun, e32, e8;
        logic [3:0] a_ctl, a_ctl8, x_ctl, fa_ctl;

        syms.delete();
        syms.push_back(SZ);
        prev = 0;
        for (int j = 0; j < fr_n; j++) begin
            s_start[j] = syms.size();
            nbt = (fr_nb[j] == 3'd0) ? 8 : int'(fr_nb[j]);
            for (int i = 0; i < nbt; i++) begin
                b = int'(fr_data[j][i]);
                syms.push_back(b != 0 ? SX : (prev != 0 ? SY : SZ));
                prev = b;
            end
            if (fr_nb[j] == 3'd0) begin
                b = ($countones(fr_data[j]) % 2 == 0) ? 1 : 0;
                syms.push_back(b != 0 ? SX : (prev != 0 ? SY : SZ));
                prev = b;
            end
        end
        syms.push_back(prev != 0 ? SY : SZ);
        syms.push_back(SY);
        n_cyc = 128 * syms.size();
        urun  = !fr_last[fr_n-1];
        for (int j = 0; j < 4; j++) begin
            load_c[j] = (j == 0) ? 0 : ((j < fr_n) ? 128 * s_start[j] - 1 : 0);
            hs_c[j]   = 1 << 30;
        end
        hs_c[0] = -2;

        if (!pre_offered) begin
            @(posedge osc_clk);
            tx_data = fr_data[0]; tx_nbits = fr_nb[0]; tx_last = fr_last[0]; tx_valid = 1'b1;
        end
        @(posedge osc_clk);
        tx_valid = 1'b0;
        @(posedge osc_clk);

        idx = 1; off_at = 1 + int'($urandom_range(0, 40)); offering = 1'b0;
        m32 = 0; m8 = 0; mc = 0; f32 = 0; f8 = 0; fc = 0; fa_ctl = '0; x_ctl = '0;
        hi32 = 0; hi8 = 0;
        for (int c = 0; c <= n_cyc; c++) begin
            if (c > 0) @(posedge osc_clk);
            e_ready = 1'b1;
            for (int j = 0; j < fr_n; j++)
                if (hs_c[j] < c && c <= load_c[j]) e_ready = 1'b0;
            e_busy = (c < n_cyc);
            e_done = (c == n_cyc) && !urun;
            e_urun = (c == n_cyc) && urun;
            e32 = exp_pause(32, c - 1);
            e8  = exp_pause(8, c - 1);
            if (mod_pause === 1'b1) hi32++;
            if (mod_pause8 === 1'b1) hi8++;
            if (mod_pause !== e32) begin if (m32 == 0) f32 = c; m32++; end
            if (mod_pause8 !== e8) begin if (m8 == 0) f8 = c; m8++; end
            a_ctl  = {tx_ready, busy, done, underrun};
            a_ctl8 = {tx_ready8, busy8, done8, underrun8};
            if (a_ctl !== {e_ready, e_busy, e_done, e_urun} || a_ctl8 !== {e_ready, e_busy, e_done, e_urun}) begin
                if (mc == 0) begin fc = c; fa_ctl = a_ctl; x_ctl = {e_ready, e_busy, e_done, e_urun}; end
                mc++;
            end
            if (offering) begin
                tx_valid = 1'b0; offering = 1'b0;
                off_at = load_c[idx] + 1 + int'($urandom_range(0, 40));
                idx++;
            end
            if (!offering && idx < fr_n && c >= off_at && tx_ready === 1'b1) begin
                tx_data = fr_data[idx]; tx_nbits = fr_nb[idx]; tx_last = fr_last[idx];
                tx_valid = 1'b1; hs_c[idx] = c; offering = 1'b1;
            end
            if (c == n_cyc && chain) begin
                tx_data = nd; tx_nbits = nnb; tx_last = nl; tx_valid = 1'b1;
            end
        end
        if (offering && !chain) tx_valid = 1'b0;

        chk_cnt++;
        if (m32 !== 0) $display("FAIL %s pause32: %0d bad cycles, first at c=%0d got %b want %b",
                                name, m32, f32, !exp_pause(32, f32 - 1), exp_pause(32, f32 - 1));
        else pass_cnt++;
        chk_cnt++;
        if (m8 !== 0) $display("FAIL %s pause8: %0d bad cycles, first at c=%0d got %b want %b",
                               name, m8, f8, !exp_pause(8, f8 - 1), exp_pause(8, f8 - 1));
        else pass_cnt++;
        chk_cnt++;
        if (mc !== 0) $display("FAIL %s ctrl{ready,busy,done,underrun}: %0d bad cycles, first at c=%0d got %b want %b",
                               name, mc, fc, fa_ctl, x_ctl);
        else pass_cnt++;

        if (!chain) begin
            @(posedge osc_clk);
            chk_cnt++;
            if ({mod_pause, mod_pause8, busy, done, underrun, tx_ready} !== 6'b000001)
                $display("FAIL %s tail: got %b want 000001", name,
                         {mod_pause, mod_pause8, busy, done, underrun, tx_ready});
            else pass_cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_nbits = '0; tx_last = 1'b0;
        repeat (3) @(posedge osc_clk);
        chk_cnt++;
        if ({mod_pause, tx_ready, busy, done, underrun} !== 5'b01000)
            $display("FAIL reset_state: got %b want 01000", {mod_pause, tx_ready, busy, done, underrun});
        else pass_cnt++;
        rst = 1'b0;
        repeat (2) @(posedge osc_clk);
        chk_cnt++;
        if ({mod_pause8, tx_ready8, busy8, done8, underrun8} !== 5'b01000)
            $display("FAIL reset_idle8: got %b want 01000", {mod_pause8, tx_ready8, busy8, done8, underrun8});
        else pass_cnt++;
    endtask

    task automatic test_reqa(input string name);
        fr_n = 1; set_byte(0, 8'h26, 3'd7, 1'b1);
        run_frame(name, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_full_byte;
        fr_n = 1; set_byte(0, 8'h93, 3'd0, 1'b1);
        run_frame("full_93", 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_two_byte;
        fr_n = 2; set_byte(0, 8'h93, 3'd0, 1'b0); set_byte(1, 8'h20, 3'd0, 1'b1);
        run_frame("two_byte", 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_underrun;
        fr_n = 1; set_byte(0, 8'h00, 3'd0, 1'b0);
        run_frame("underrun", 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_reset_mid_frame;
        int bad;
        @(posedge osc_clk);
        tx_data = 8'h26; tx_nbits = 3'd7; tx_last = 1'b1; tx_valid = 1'b1;
        @(posedge osc_clk); tx_valid = 1'b0;
        @(posedge osc_clk);                      // SOC ph=0
        repeat (5) @(posedge osc_clk);
        tx_data = 8'hA5; tx_nbits = 3'd0; tx_last = 1'b1; tx_valid = 1'b1;
        @(posedge osc_clk); tx_valid = 1'b0;
        repeat (4) @(posedge osc_clk);           // SOC ph=10
        chk_cnt++;
        if ({mod_pause, tx_ready} !== 2'b10)
            $display("FAIL rst_pre{pause,ready}: got %b want 10", {mod_pause, tx_ready});
        else pass_cnt++;
        rst = 1'b1;
        @(posedge osc_clk);
        chk_cnt++;
        if ({mod_pause, busy, tx_ready, done, underrun, mod_pause8, busy8} !== 7'b0010000)
            $display("FAIL rst_post: got %b want 0010000",
                     {mod_pause, busy, tx_ready, done, underrun, mod_pause8, busy8});
        else pass_cnt++;
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge osc_clk);
            if ({mod_pause, busy, tx_ready, done, underrun} !== 5'b00100) bad++;
        end
        chk_cnt++;
        if (bad !== 0) $display("FAIL rst_quiet: %0d bad cycles want 0", bad);
        else pass_cnt++;
        test_reqa("reqa_after_rst");
    endtask

    task automatic test_pause8;
        test_reqa("reqa_p8");
        chk_cnt++;
        if (hi8 !== 7 * 8) $display("FAIL pause8_width: got %0d high cycles want %0d", hi8, 7 * 8);
        else pass_cnt++;
        chk_cnt++;
        if (hi32 !== 7 * 32) $display("FAIL pause32_width: got %0d high cycles want %0d", hi32, 7 * 32);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        fr_n = 1; set_byte(0, 8'h93, 3'd0, 1'b1);
        run_frame("b2b_a", 1'b0, 1'b1, 8'h26, 3'd7, 1'b1);
        fr_n = 1; set_byte(0, 8'h26, 3'd7, 1'b1);
        run_frame("b2b_b", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_random;
        for (int f = 0; f < 6; f++) begin
            fr_n = int'($urandom_range(1, 3));
            for (int j = 0; j < fr_n; j++)
                set_byte(j, 8'($urandom),
                         ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                         j == fr_n - 1);
            if ($urandom_range(0, 4) == 0) fr_last[fr_n-1] = 1'b0;
            run_frame("random", 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_reqa("reqa");
        test_full_byte();
        test_two_byte();
        test_underrun();
        test_reset_mid_frame();
        test_pause8();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
